// File: rtl/cmd_frame_master_pkg.sv
// Shared command-frame definitions: wire command bytes, request types, Gray-coded FSM states,
// and the frame byte selector used by the serializer.
package cmd_frame_master_pkg;

  localparam logic [7:0] CMD_RF_WR   = 8'hAA;
  localparam logic [7:0] CMD_RF_RD   = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  typedef enum logic [1:0] {
    REQ_RF_WR   = 2'd0,
    REQ_RF_RD   = 2'd1,
    REQ_ALU_OP  = 2'd2,
    REQ_ALU_NOP = 2'd3
  } req_type_e;

  // Gray sequence so the host and slave controllers decode identical state words.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_SEND    = 2'b01,
    ST_WAIT_LO = 2'b11,
    ST_WAIT_HI = 2'b10
  } state_e;

  typedef struct packed {
    req_type_e  typ;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic [7:0] fun;
  } req_t;

  function automatic logic [7:0] frame_byte(input req_t r, input logic [1:0] idx);
    logic [7:0] b;
    b = 8'h00;
    case (r.typ)
      REQ_RF_WR: begin
        case (idx)
          2'd0:    b = CMD_RF_WR;
          2'd1:    b = r.addr;
          default: b = r.wdata;
        endcase
      end
      REQ_RF_RD:  b = (idx == 2'd0) ? CMD_RF_RD : r.addr;
      REQ_ALU_OP: begin
        case (idx)
          2'd0:    b = CMD_ALU_OP;
          2'd1:    b = r.op_a;
          2'd2:    b = r.op_b;
          default: b = r.fun;
        endcase
      end
      default:    b = (idx == 2'd0) ? CMD_ALU_NOP : r.fun;
    endcase
    return b;
  endfunction

  function automatic logic [1:0] frame_last(input req_type_e t);
    logic [1:0] last;
    case (t)
      REQ_RF_WR:  last = 2'd2;
      REQ_ALU_OP: last = 2'd3;
      default:    last = 2'd1;
    endcase
    return last;
  endfunction

endpackage

// File: rtl/cmd_frame_rsp_collect.sv
// Response byte assembly (LSB first) for WAIT_LO/WAIT_HI; result registered, pulses 1 cycle after the last RX byte.
// RSP_TIMEOUT_EN adds a wait counter that abandons the response after TIMEOUT_CYCLES idle cycles.
module cmd_frame_rsp_collect #(
  parameter int RSP_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 wait_lo,
  input  logic                 wait_hi,
  input  logic                 two_byte,
  input  logic [7:0]           rx_dat,
  input  logic                 rx_vld,
  output logic                 rsp_vld,
  output logic [RSP_WIDTH-1:0] rsp_dat,
  output logic                 rsp_tmo,
  output logic                 adv_hi,
  output logic                 done
);

  if (RSP_WIDTH != 16 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("cmd_frame_rsp_collect: RSP_WIDTH must be 16 and TIMEOUT_CYCLES at least 2");
  end

  logic [7:0]           lo_q, lo_d;
  logic [RSP_WIDTH-1:0] rsp_dat_q, rsp_dat_d;
  logic                 rsp_vld_q, rsp_vld_d;
  logic                 expired;

`ifdef RSP_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo_q;

  // Held at zero outside the wait states, so entering WAIT_LO always starts from a cleared count.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (!(wait_lo || wait_hi) || rx_vld) begin
      cnt_d = '0;
    end
  end

  assign expired = (wait_lo || wait_hi) && !rx_vld && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= expired;
    end
  end

  assign rsp_tmo = tmo_q;
`else
  assign expired = 1'b0;
  assign rsp_tmo = 1'b0;
`endif

  // A coincident RX byte takes priority over expiry.
  always_comb begin
    lo_d      = lo_q;
    rsp_dat_d = rsp_dat_q;
    rsp_vld_d = 1'b0;
    adv_hi    = 1'b0;
    done      = 1'b0;
    if (wait_lo && rx_vld) begin
      if (two_byte) begin
        lo_d   = rx_dat;
        adv_hi = 1'b1;
      end else begin
        rsp_dat_d = RSP_WIDTH'({8'h00, rx_dat});
        rsp_vld_d = 1'b1;
        done      = 1'b1;
      end
    end else if (wait_hi && rx_vld) begin
      rsp_dat_d = RSP_WIDTH'({rx_dat, lo_q});
      rsp_vld_d = 1'b1;
      done      = 1'b1;
    end else if (expired) begin
      rsp_dat_d = '0;
      done      = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      lo_q      <= '0;
      rsp_dat_q <= '0;
      rsp_vld_q <= 1'b0;
    end else begin
      lo_q      <= lo_d;
      rsp_dat_q <= rsp_dat_d;
      rsp_vld_q <= rsp_vld_d;
    end
  end

  assign rsp_vld = rsp_vld_q;
  assign rsp_dat = rsp_dat_q;

endmodule

// File: rtl/cmd_frame_master.sv
// Serializes one accepted request into a UART command frame: first byte 1 cycle after accept, one per !TX_BUSY cycle.
// REQ_READY only in IDLE; optional response timeout under RSP_TIMEOUT_EN.
module cmd_frame_master
  import cmd_frame_master_pkg::*;
#(
  parameter int ADDR_WIDTH     = 4,
  parameter int ALU_FUN_WIDTH  = 4,
  parameter int RSP_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     REQ_VALID,
  output logic                     REQ_READY,
  input  logic [1:0]               REQ_TYPE,
  input  logic [ADDR_WIDTH-1:0]    REQ_ADDR,
  input  logic [7:0]               REQ_WDATA,
  input  logic [7:0]               REQ_OP_A,
  input  logic [7:0]               REQ_OP_B,
  input  logic [ALU_FUN_WIDTH-1:0] REQ_ALU_FUN,
  output logic [7:0]               TX_DATA,
  output logic                     TX_VALID,
  input  logic                     TX_BUSY,
  input  logic [7:0]               RX_DATA,
  input  logic                     RX_VALID,
  output logic                     RSP_VALID,
  output logic [RSP_WIDTH-1:0]     RSP_DATA,
  output logic                     RSP_TIMEOUT,
  output logic                     BUSY
);

  state_e     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic       tx_valid_q, tx_valid_d;
  logic [7:0] tx_data_q, tx_data_d;
  req_t       req_q, req_d, req_in;
  logic       tx_fire;
  logic       rsp_adv;
  logic       rsp_done;

  always_comb begin
    req_in       = '0;
    req_in.typ   = req_type_e'(REQ_TYPE);
    req_in.addr  = 8'(REQ_ADDR);
    req_in.wdata = REQ_WDATA;
    req_in.op_a  = REQ_OP_A;
    req_in.op_b  = REQ_OP_B;
    req_in.fun   = 8'(REQ_ALU_FUN);
  end

  assign tx_fire = tx_valid_q && !TX_BUSY;

  // TX_DATA is preloaded with the next byte so it is already stable while the UART is busy.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    req_d      = req_q;
    case (state_q)
      ST_IDLE: begin
        if (REQ_VALID) begin
          req_d      = req_in;
          idx_d      = 2'd0;
          tx_valid_d = 1'b1;
          tx_data_d  = frame_byte(req_in, 2'd0);
          state_d    = ST_SEND;
        end
      end
      ST_SEND: begin
        if (tx_fire) begin
          if (idx_q == frame_last(req_q.typ)) begin
            tx_valid_d = 1'b0;
            if (req_q.typ == REQ_RF_WR) begin
              state_d = ST_IDLE;
            end else begin
              state_d = ST_WAIT_LO;
            end
          end else begin
            idx_d     = idx_q + 2'd1;
            tx_data_d = frame_byte(req_q, idx_q + 2'd1);
          end
        end
      end
      ST_WAIT_LO: begin
        if (rsp_done) begin
          state_d = ST_IDLE;
        end else if (rsp_adv) begin
          state_d = ST_WAIT_HI;
        end
      end
      ST_WAIT_HI: begin
        if (rsp_done) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      req_q      <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      req_q      <= req_d;
    end
  end

  cmd_frame_rsp_collect #(
    .RSP_WIDTH      (RSP_WIDTH),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rsp_collect (
    .CLK      (CLK),
    .RST      (RST),
    .wait_lo  (state_q == ST_WAIT_LO),
    .wait_hi  (state_q == ST_WAIT_HI),
    .two_byte (req_q.typ != REQ_RF_RD),
    .rx_dat   (RX_DATA),
    .rx_vld   (RX_VALID),
    .rsp_vld  (RSP_VALID),
    .rsp_dat  (RSP_DATA),
    .rsp_tmo  (RSP_TIMEOUT),
    .adv_hi   (rsp_adv),
    .done     (rsp_done)
  );

  assign REQ_READY = (state_q == ST_IDLE);
  assign BUSY      = (state_q != ST_IDLE);
  assign TX_VALID  = tx_valid_q;
  assign TX_DATA   = tx_data_q;

endmodule
